// File: rtl/sample_collector.sv
// sample_collector: round-robin pin sample poller feeding a first-word-fall-through FIFO
module sample_collector #(
  parameter int NUM_CHANNELS = 8,
  parameter int FIFO_DEPTH   = 64,
  parameter int ADDR_W       = 6,
  parameter int RD_LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  output logic              output_sample,
  output logic [7:0]        channel_select,
  input  logic [31:0]       sample_data,
  input  logic              fifo_rd,
  output logic [31:0]       fifo_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [1:0] wait_q, wait_d;
  logic req_q, req_d, ovf_q, ovf_d;
  logic [7:0] sel_q, sel_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [15:0] last_q [NUM_CHANNELS];
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [15:0] cnt, last;
  logic [14:0] pos;
  logic capt, take, push, full, empty, wr, rd;
  always_comb begin
    cnt = sample_data[31:16];
    pos = sample_data[15:1];
    last = last_q[ch_q];
    capt = state_q == CAPT;
    // a word tagged for another channel is ignored unless it is all-zero (absent pin)
    take = capt && (pos == 15'(ch_q) || sample_data == '0);
    push = take && cnt != 16'd0 && cnt != last;
    full = count_q == (ADDR_W+1)'(FIFO_DEPTH);
    empty = count_q == '0;
    wr = push && !full;
    rd = fifo_rd && !empty;
    ovf_d = ovf_q | (push && full);
    wptr_d = wptr_q + ADDR_W'(wr);
    rptr_d = rptr_q + ADDR_W'(rd);
    count_d = count_q + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
    ch_d = capt ? (ch_q == CW'(NUM_CHANNELS-1) ? '0 : ch_q + CW'(1)) : ch_q;
    state_d = state_q;
    wait_d = wait_q;
    unique case (state_q)
      IDLE: state_d = enable ? REQ : IDLE;
      REQ: begin
        state_d = RD_LATENCY > 1 ? WAIT : CAPT;
        wait_d = 2'(RD_LATENCY-2);
      end
      WAIT: begin
        state_d = wait_q == 2'd0 ? CAPT : WAIT;
        wait_d = wait_q - 2'd1;
      end
      CAPT: state_d = enable ? REQ : IDLE;
    endcase
    req_d = state_d == REQ;
    sel_d = state_d == REQ ? 8'(ch_d) : sel_q;
    if (clear) begin
      state_d = IDLE;
      ch_d = '0;
      req_d = 1'b0;
      sel_d = '0;
      wptr_d = '0;
      rptr_d = '0;
      count_d = '0;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q <= '0;
      wait_q <= '0;
      req_q <= 1'b0;
      sel_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) last_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      wait_q <= wait_d;
      req_q <= req_d;
      sel_q <= sel_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (clear) last_q[i] <= '0;
        else if (take && ch_q == CW'(i)) last_q[i] <= cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !clear) mem_q[wptr_q] <= sample_data;
  end
  assign output_sample = req_q;
  assign channel_select = sel_q;
  assign fifo_data = empty ? '0 : mem_q[rptr_q];
  assign fifo_empty = empty;
  assign fifo_full = full;
  assign fifo_count = count_q;
  assign overflow = ovf_q;
endmodule
